// File: rtl/adc_frame_sequencer_pkg.sv
// Shared encodings for the ADC SPI frame sequencer: FSM states, frame layout,
// channel-mode codes and the channel schedule helper.
package adc_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    MODE_CH0       = 2'b00,
    MODE_CH1       = 2'b01,
    MODE_ALT       = 2'b10,
    MODE_CH0_ALIAS = 2'b11
  } chan_mode_e;

  // Frame on DOUT, MSB first: lead 0, D11..D0, two trailing zeros, Z.
  localparam int FRAME_BITS   = 16;
  localparam int BIT_CNT_W    = 5;
  localparam int LEAD_POS     = 15;
  localparam int DATA_MSB     = 14;
  localparam int DATA_LSB     = 3;
  localparam int TRAIL_HI_POS = 2;
  localparam int TRAIL_LO_POS = 1;
  localparam int SAMPLE_W     = DATA_MSB - DATA_LSB + 1;

  function automatic logic sched_chan(input logic [1:0] mode, input logic alt_ptr);
    logic ch;
    ch = 1'b0;
    case (mode)
      MODE_CH1: ch = 1'b1;
      MODE_ALT: ch = alt_ptr;
      default:  ch = 1'b0;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period divider: pulses tick_o every HALF_DIV clocks; clr_i holds the
// count at zero so the first half-period after a clear is full length.
module sclk_tick_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_frame_sequencer.sv
// SPI master for a dual-channel 12-bit SAR ADC: issues one nCS/SCLK frame per
// sample period, schedules CHSEL, and emits one tagged 12-bit sample per frame.
module adc_frame_sequencer
  import adc_frame_sequencer_pkg::*;
#(
  parameter int HALF_DIV      = 2,
  parameter int SAMPLE_PERIOD = 80,
  parameter int PER_W         = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                enable,
  input  logic [1:0]          chan_mode,
  output logic                nCS,
  output logic                SCLK,
  output logic                CHSEL,
  input  logic                DOUT,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_chan,
  output logic                sample_err,
  output logic                sample_valid,
  output logic                late,
  output seq_state_e          dbg_state_o
);

  localparam logic [PER_W-1:0]     PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [BIT_CNT_W-1:0] BITS_END = BIT_CNT_W'(FRAME_BITS);

  seq_state_e                state_q, state_d;
  logic [PER_W-1:0]          per_q, per_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]     sr_q, sr_d;
  logic                      ncs_q, ncs_d;
  logic                      sclk_q, sclk_d;
  logic                      chsel_q, chsel_d;
  logic                      alt_q, alt_d;
  logic                      frame_alt_q, frame_alt_d;
  logic                      pend_q, pend_d;
  logic                      late_q, late_d;
  logic [SAMPLE_W-1:0]       data_q, data_d;
  logic                      chan_q, chan_d;
  logic                      err_q, err_d;
  logic                      valid_q, valid_d;
  logic                      tick;
  logic                      period_evt;

  sclk_tick_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_tick (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (state_q == ST_IDLE),
    .tick_o(tick)
  );

  // The counter sits at zero for one clock per period while enabled; that
  // clock is the period event, and enable rising from a held-zero counter
  // therefore starts a frame straight away.
  assign period_evt = enable && (per_q == '0);

  always_comb begin
    per_d = '0;
    if (enable && (per_q != PER_LAST)) begin
      per_d = per_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    ncs_d       = ncs_q;
    sclk_d      = sclk_q;
    chsel_d     = chsel_q;
    alt_d       = alt_q;
    frame_alt_d = frame_alt_q;
    pend_d      = pend_q;
    late_d      = late_q;
    data_d      = data_q;
    chan_d      = chan_q;
    err_d       = err_q;
    valid_d     = 1'b0;

    // At most one overrun start is remembered; dropping enable forgets it.
    if (!enable) begin
      pend_d = 1'b0;
    end else if (period_evt && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
      late_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && (period_evt || pend_q)) begin
          chsel_d     = sched_chan(chan_mode, alt_q);
          frame_alt_d = (chan_mode == MODE_ALT);
          ncs_d       = 1'b0;
          bit_cnt_d   = '0;
          pend_d      = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tick) begin
          sclk_d    = 1'b1;
          sr_d      = {sr_q[FRAME_BITS-2:0], DOUT};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          if (bit_cnt_q == BITS_END) begin
            ncs_d   = 1'b1;
            state_d = ST_HOLD;
          end else begin
            sclk_d  = 1'b0;
            state_d = ST_LOW;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          data_d  = sr_q[DATA_MSB:DATA_LSB];
          chan_d  = chsel_q;
          err_d   = sr_q[LEAD_POS] | sr_q[TRAIL_HI_POS] | sr_q[TRAIL_LO_POS];
          valid_d = 1'b1;
          if (frame_alt_q) begin
            alt_d = ~alt_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        ncs_d   = 1'b1;
        sclk_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      per_q       <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      ncs_q       <= 1'b1;
      sclk_q      <= 1'b1;
      chsel_q     <= 1'b0;
      alt_q       <= 1'b0;
      frame_alt_q <= 1'b0;
      pend_q      <= 1'b0;
      late_q      <= 1'b0;
      data_q      <= '0;
      chan_q      <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      ncs_q       <= ncs_d;
      sclk_q      <= sclk_d;
      chsel_q     <= chsel_d;
      alt_q       <= alt_d;
      frame_alt_q <= frame_alt_d;
      pend_q      <= pend_d;
      late_q      <= late_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
    end
  end

  assign nCS          = ncs_q;
  assign SCLK         = sclk_q;
  assign CHSEL        = chsel_q;
  assign sample_data  = data_q;
  assign sample_chan  = chan_q;
  assign sample_err   = err_q;
  assign sample_valid = valid_q;
  assign late         = late_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Bench for adc_frame_sequencer: instance 0 (period 40) runs the table, random,
// reset and enable-drop sequences; instance 1 (period 20) runs overrun frames.
module tb_adc_frame_sequencer;
  import adc_frame_sequencer_pkg::*;

  localparam int NI = 2;
  localparam int W  = 14;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [NI] = '{default: 1'b1};
  logic       enable [NI];
  logic [1:0] chan_mode [NI];
  logic       force_lead [NI];
  logic       ncs [NI], sclk [NI], chsel [NI];
  logic       s_chan [NI], s_err [NI], s_valid [NI], late [NI];
  logic [11:0] s_data [NI];
  seq_state_e dbg [NI];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_frames [NI] = '{default: 0};
  int  n_valid  [NI] = '{default: 0};
  int  rises    [NI] = '{default: 0};
  bit  chk_spacing [NI] = '{default: 1'b0};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC behavioural model + scoreboard per instance
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int PER     = (g == 0) ? 40 : 20;
    localparam int SPACING = (g == 0) ? 40 : 35;

    logic          dout_m = 1'b0;
    logic [15:0]   frame_bits;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  e;
    logic          alt_ptr = 1'b0;
    logic          cur_chan = 1'b0;
    int            adc_val = 0;
    int            falls = 0;
    time           t_last = 0;

    adc_frame_sequencer #(
      .HALF_DIV(1), .SAMPLE_PERIOD(PER), .PER_W(16)
    ) u_dut (
      .CLK(clk), .RST(rst[g]), .enable(enable[g]), .chan_mode(chan_mode[g]),
      .nCS(ncs[g]), .SCLK(sclk[g]), .CHSEL(chsel[g]), .DOUT(dout_m),
      .sample_data(s_data[g]), .sample_chan(s_chan[g]), .sample_err(s_err[g]),
      .sample_valid(s_valid[g]), .late(late[g]), .dbg_state_o(dbg[g])
    );

    always @(negedge ncs[g]) begin
      adc_val = adc_val + 1;
      case (chan_mode[g])
        2'b01:   cur_chan = 1'b1;
        2'b10: begin
          cur_chan = alt_ptr;
          alt_ptr  = ~alt_ptr;
        end
        default: cur_chan = 1'b0;
      endcase
      frame_bits = {force_lead[g], 12'(adc_val), 2'b00, 1'($urandom)};
      dout_m     = frame_bits[15];
      falls      = 0;
      rises[g]   = 0;
      exp_q.push_back({force_lead[g], cur_chan, 12'(adc_val)});
      if (chk_spacing[g] && n_frames[g] > 0)
        check($sformatf("ncs_spacing%0d", g), int'(($time - t_last) / 10), SPACING);
      t_last = $time;
      n_frames[g]++;
    end

    always @(negedge sclk[g]) begin
      if (!ncs[g]) begin
        falls++;
        if (falls <= 16) dout_m = frame_bits[16 - falls];
      end
    end

    always @(posedge sclk[g]) begin
      if (!ncs[g]) rises[g]++;
    end

    always @(posedge ncs[g]) begin
      if (!rst[g]) check($sformatf("sclk_rises%0d", g), rises[g], 16);
    end

    always @(posedge rst[g]) begin
      exp_q.delete();
      alt_ptr = 1'b0;
    end

    always @(negedge clk) begin
      if (!rst[g] && !ncs[g])
        check($sformatf("chsel_in_frame%0d", g), int'(chsel[g]), int'(cur_chan));
      if (s_valid[g]) begin
        n_valid[g]++;
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_valid%0d", g), 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("sb_data%0d", g), int'(s_data[g]), int'(e[11:0]));
          check($sformatf("sb_chan%0d", g), int'(s_chan[g]), int'(e[12]));
          check($sformatf("sb_err%0d", g), int'(s_err[g]), int'(e[13]));
        end
      end
    end
  end

  // driver tasks
  task automatic wait_valid(input int g, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (s_valid[g]) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("valid_within_budget%0d", g), int'(ok), 1);
  endtask

  task automatic wait_rise(input int g, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!ncs[g] && rises[g] == n) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("reach_rise%0d_%0d", n, g), int'(ok), 1);
  endtask

  typedef struct packed {
    logic [1:0]  mode;
    logic        force_l;
    logic [11:0] data;
    logic        chan;
    logic        err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit  ok;
    time t_rel;
    int  frames_snap;

    tbl[0]  = '{2'b00, 1'b0, 12'h001, 1'b0, 1'b0};
    tbl[1]  = '{2'b00, 1'b0, 12'h002, 1'b0, 1'b0};
    tbl[2]  = '{2'b00, 1'b0, 12'h003, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 1'b0, 12'h004, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 1'b0, 12'h005, 1'b1, 1'b0};
    tbl[5]  = '{2'b10, 1'b0, 12'h006, 1'b0, 1'b0};
    tbl[6]  = '{2'b10, 1'b0, 12'h007, 1'b1, 1'b0};
    tbl[7]  = '{2'b00, 1'b1, 12'h008, 1'b0, 1'b1};
    tbl[8]  = '{2'b00, 1'b0, 12'h009, 1'b0, 1'b0};
    tbl[9]  = '{2'b01, 1'b0, 12'h00A, 1'b1, 1'b0};
    tbl[10] = '{2'b11, 1'b0, 12'h00B, 1'b0, 1'b0};
    tbl[11] = '{2'b10, 1'b0, 12'h00C, 1'b0, 1'b0};

    enable     = '{default: 1'b0};
    chan_mode  = '{default: 2'b00};
    force_lead = '{default: 1'b0};

    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_ncs%0d", g), int'(ncs[g]), 1);
      check($sformatf("rst_sclk%0d", g), int'(sclk[g]), 1);
      check($sformatf("rst_chsel%0d", g), int'(chsel[g]), 0);
      check($sformatf("rst_data%0d", g), int'(s_data[g]), 0);
      check($sformatf("rst_valid%0d", g), int'(s_valid[g]), 0);
      check($sformatf("rst_late%0d", g), int'(late[g]), 0);
      check($sformatf("rst_state%0d", g), int'(dbg[g]), int'(ST_IDLE));
    end

    // first frame starts on the clock after release with counter at zero
    enable       = '{default: 1'b1};
    chan_mode[0] = tbl[0].mode;
    chk_spacing  = '{default: 1'b1};
    rst          = '{default: 1'b0};
    t_rel        = $time;
    for (int c = 0; c < 10 && n_frames[0] == 0; c++) @(negedge clk);
    check("first_frame_started", int'(n_frames[0] > 0), 1);
    check("first_fall_delay", int'(g_inst[0].t_last - t_rel), 5);

    // table-driven frames on instance 0
    for (int i = 0; i < 12; i++) begin
      chan_mode[0]  = tbl[i].mode;
      force_lead[0] = tbl[i].force_l;
      wait_valid(0, 200, ok);
      check($sformatf("tbl%0d_data", i), int'(s_data[0]), int'(tbl[i].data));
      check($sformatf("tbl%0d_chan", i), int'(s_chan[0]), int'(tbl[i].chan));
      check($sformatf("tbl%0d_err", i), int'(s_err[0]), int'(tbl[i].err));
    end

    // randomized modes and framing errors, checked by the scoreboard
    for (int i = 0; i < 10; i++) begin
      chan_mode[0]  = 2'($urandom_range(0, 3));
      force_lead[0] = ($urandom_range(0, 3) == 0);
      wait_valid(0, 200, ok);
    end

    // reset at the seventh SCLK rise of a frame
    chan_mode[0]   = 2'b00;
    force_lead[0]  = 1'b0;
    chk_spacing[0] = 1'b0;
    wait_rise(0, 7, 200, ok);
    rst[0] = 1'b1;
    #1;
    check("midframe_rst_ncs", int'(ncs[0]), 1);
    check("midframe_rst_sclk", int'(sclk[0]), 1);
    check("midframe_rst_state", int'(dbg[0]), int'(ST_IDLE));
    repeat (3) begin
      @(negedge clk);
      check("midframe_rst_no_valid", int'(s_valid[0]), 0);
    end
    rst[0] = 1'b0;
    wait_valid(0, 200, ok);
    check("post_rst_err", int'(s_err[0]), 0);

    // enable dropped during bit 10
    wait_rise(0, 10, 200, ok);
    enable[0] = 1'b0;
    wait_valid(0, 200, ok);
    frames_snap = n_frames[0];
    repeat (100) @(negedge clk);
    check("no_start_while_disabled", n_frames[0], frames_snap);
    check("idle_while_disabled", int'(dbg[0]), int'(ST_IDLE));
    enable[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("restart_on_enable", n_frames[0], frames_snap + 1);
    wait_valid(0, 200, ok);

    // overrunning instance: late set, every started frame delivered
    check("late_slow_clear", int'(late[0]), 0);
    check("late_fast_set", int'(late[1]), 1);
    check("fast_frames_seen", int'(n_frames[1] > 20), 1);
    check("fast_all_valid", int'(n_valid[1] >= n_frames[1] - 1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
